// File: rtl/axis_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : axis_uart_pkg
// Brief  : Shared types and constants for the UART TX stream arbiter.
//          Provides the arbiter FSM state encoding, the width of the
//          source-ID field carried in the header byte, the default header
//          base value and the UART byte width.
// Rev    : 1.0  initial release
// ============================================================================
package axis_uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  // Requester index width; also the number of header bits that carry the ID.
  localparam int         HDR_ID_BITS      = 3;
  localparam logic [7:0] HDR_BASE_DEFAULT = 8'hA0;
  localparam int         UART_BYTE_W      = 8;

endpackage : axis_uart_pkg
`default_nettype wire

// File: rtl/rr_priority_select.sv
`default_nettype none
// ============================================================================
// Module : rr_priority_select
// Brief  : Combinational round-robin picker. Searches the request vector
//          starting one position above last_i and wrapping modulo N_REQ.
//          Returns a one-hot grant, its index and a valid flag.
// Ports  : req_i   [N_REQ]  request vector
//          last_i  [IDX_W]  most recently served index
//          gnt_o   [N_REQ]  one-hot grant (zero when nothing requested)
//          idx_o   [IDX_W]  index of the granted bit
//          valid_o          any request present
// Rev    : 1.0  initial release
// ============================================================================
module rr_priority_select #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 3
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // One extra bit so last_i + offset cannot overflow before the wrap.
  localparam int             CW      = IDX_W + 1;
  localparam logic [CW-1:0]  C_NREQ  = CW'(N_REQ);

  logic [CW-1:0] cand;

  // Walk offsets 1..N_REQ from last_i; the first requesting candidate wins.
  // The inner equality loop avoids a variable-width bit select into req_i.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = {1'b0, last_i} + CW'(i);
      if (cand >= C_NREQ) begin
        cand = cand - C_NREQ;
      end
      for (int j = 0; j < N_REQ; j++) begin
        if (!valid_o && req_i[j] && (cand == CW'(j))) begin
          valid_o  = 1'b1;
          gnt_o[j] = 1'b1;
          idx_o    = IDX_W'(j);
        end
      end
    end
  end

endmodule : rr_priority_select
`default_nettype wire

// File: rtl/axis_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module : axis_uart_tx_arbiter
// Brief  : Packet-aware round-robin arbiter sharing one UART TX byte stream
//          between N_REQ AXI-Stream requesters. Each grant lasts until the
//          tlast beat (or until MAX_LEN beats, when the watchdog revokes it)
//          and is optionally prefixed by a header byte HDR_BASE | grant_id.
// Ports  : clk, rst                 clock, synchronous active-high reset
//          s_tdata  [8*N_REQ]       requester data, requester k at [8k+7:8k]
//          s_tvalid/s_tlast [N_REQ] requester valid / end of packet
//          s_tready [N_REQ]         requester ready, at most one bit high
//          m_tdata/m_tvalid         stream to the UART TX wrapper
//          m_tready                 ready from the UART TX wrapper
//          grant_id [3]             current or most recent grant
//          busy                     FSM outside IDLE
//          wdog_trip                one-cycle pulse on watchdog revocation
// Rev    : 1.0  initial release
// ============================================================================
module axis_uart_tx_arbiter
  import axis_uart_pkg::*;
#(
  parameter int         N_REQ    = 4,
  parameter int         HDR_EN   = 1,
  parameter logic [7:0] HDR_BASE = HDR_BASE_DEFAULT,
  parameter int         MAX_LEN  = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [UART_BYTE_W*N_REQ-1:0]   s_tdata,
  input  logic [N_REQ-1:0]               s_tvalid,
  input  logic [N_REQ-1:0]               s_tlast,
  output logic [N_REQ-1:0]               s_tready,
  output logic [UART_BYTE_W-1:0]         m_tdata,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic [HDR_ID_BITS-1:0]         grant_id,
  output logic                           busy,
  output logic                           wdog_trip
);

  localparam logic [HDR_ID_BITS-1:0] LAST_RST = HDR_ID_BITS'(N_REQ - 1);
  localparam logic [7:0]             C_MAX    = 8'(MAX_LEN);

  arb_state_e                 state_q, state_d;
  logic [HDR_ID_BITS-1:0]     last_q, last_d;
  logic [HDR_ID_BITS-1:0]     grant_q, grant_d;
  logic [N_REQ-1:0]           gnt_oh_q, gnt_oh_d;
  logic [7:0]                 len_q, len_d;
  logic                       wdog_q, wdog_d;

  logic [N_REQ-1:0]           sel_gnt;
  logic [HDR_ID_BITS-1:0]     sel_idx;
  logic                       sel_valid;

  logic [UART_BYTE_W-1:0]     gnt_data;
  logic                       gnt_valid;
  logic                       gnt_last;
  logic [7:0]                 len_inc;
  logic [UART_BYTE_W-1:0]     hdr_byte;

  rr_priority_select #(
    .N_REQ (N_REQ),
    .IDX_W (HDR_ID_BITS)
  ) u_rr_sel (
    .req_i   (s_tvalid),
    .last_i  (last_q),
    .gnt_o   (sel_gnt),
    .idx_o   (sel_idx),
    .valid_o (sel_valid)
  );

  // The grant is kept one-hot so the data mux is a plain AND-OR tree.
  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_oh_q[k]) begin
        gnt_data = gnt_data | s_tdata[k*UART_BYTE_W +: UART_BYTE_W];
      end
    end
  end

  assign gnt_valid = |(s_tvalid & gnt_oh_q);
  assign gnt_last  = |(s_tlast  & gnt_oh_q);
  assign len_inc   = (len_q == 8'hFF) ? len_q : (len_q + 8'd1);
  assign hdr_byte  = HDR_BASE | {{(UART_BYTE_W-HDR_ID_BITS){1'b0}}, grant_q};

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    grant_d  = grant_q;
    gnt_oh_d = gnt_oh_q;
    len_d    = len_q;
    wdog_d   = 1'b0;
    s_tready = '0;
    m_tvalid = 1'b0;
    m_tdata  = '0;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          grant_d  = sel_idx;
          gnt_oh_d = sel_gnt;
          last_d   = sel_idx;
          len_d    = '0;
          state_d  = (HDR_EN != 0) ? HDR : DATA;
        end
      end
      HDR: begin
        m_tvalid = 1'b1;
        m_tdata  = hdr_byte;
        if (m_tready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        m_tdata  = gnt_data;
        m_tvalid = gnt_valid;
        s_tready = gnt_oh_q & {N_REQ{m_tready}};
        if (gnt_valid && m_tready) begin
          len_d = len_inc;
          if (gnt_last) begin
            state_d = IDLE;
          end else if (len_inc == C_MAX) begin
            // Revoke: the rest of this packet re-arbitrates with a new header.
            state_d = IDLE;
            wdog_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= LAST_RST;
      grant_q  <= '0;
      gnt_oh_q <= N_REQ'(1);
      len_q    <= '0;
      wdog_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      gnt_oh_q <= gnt_oh_d;
      len_q    <= len_d;
      wdog_q   <= wdog_d;
    end
  end

  assign grant_id  = grant_q;
  assign busy      = (state_q != IDLE);
  assign wdog_trip = wdog_q;

endmodule : axis_uart_tx_arbiter
`default_nettype wire

// File: doc/axis_uart_tx_arbiter.md
# axis_uart_tx_arbiter

Round-robin, packet-aware arbiter that shares the single `axis_uart_tx_wrapper` byte stream between `N_REQ` AXI-Stream requesters. Arbitration is per packet, delimited by `tlast`. Each granted packet may be prefixed with a source-ID header byte so the host can demultiplex the UART stream. The arbiter sits between board-level producers (switch reporters, status loggers, echo paths) and the UART TX wrapper's `i_t*` port.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, range 2..8.
- `HDR_EN`, 1: when 1, a header byte precedes each packet.
- `HDR_BASE`, 8'hA0: header byte is `HDR_BASE | grant_id`; the low 3 bits of `HDR_BASE` must be 0.
- `MAX_LEN`, 64: watchdog limit on data beats per grant, range 1..255.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock (8 MHz domain).
- `rst`  in  1  synchronous, active-high reset.
- `s_tdata`  in  8*N_REQ  requester data; requester k occupies bits `[8k+7:8k]`.
- `s_tvalid`  in  N_REQ  per-requester valid.
- `s_tlast`  in  N_REQ  per-requester end of packet.
- `s_tready`  out  N_REQ  per-requester ready; at most one bit is high at a time.
- `m_tdata`  out  8  to the UART TX wrapper `i_tdata`.
- `m_tvalid`  out  1  to `i_tvalid`.
- `m_tready`  in  1  from `i_tready`.
- `grant_id`  out  3  index of the current or most recent grant.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `wdog_trip`  out  1  one-cycle pulse when a grant is revoked by the watchdog.

## Operation
- FSM states: IDLE, HDR, DATA.
- **IDLE**
  - `s_tready` = 0, `m_tvalid` = 0.
  - If any `s_tvalid` bit is set, select the first set bit searching from `last+1` upward, modulo `N_REQ`.
  - Register the selection as `grant_id`, set `last` = selection, clear `len_cnt`.
  - Next state is HDR if `HDR_EN`, otherwise DATA.
- **HDR**
  - `m_tvalid` = 1, `m_tdata` = `HDR_BASE | grant_id`, all `s_tready` = 0.
  - On `m_tready`, go to DATA.
- **DATA**
  - Combinational pass-through from the granted requester:
    - `m_tdata` = `s_tdata[grant_id]`
    - `m_tvalid` = `s_tvalid[grant_id]`
    - `s_tready[grant_id]` = `m_tready`; all other `s_tready` bits are 0.
  - A beat occurs when `m_tvalid & m_tready`; each beat increments `len_cnt` (8-bit, saturating).
  - A beat with `s_tlast[grant_id]` set returns the FSM to IDLE.
  - A beat that brings `len_cnt` to `MAX_LEN` without `tlast` also returns the FSM to IDLE and pulses `wdog_trip`. The remainder of that packet re-arbitrates as a new packet and receives a new header.
- The granted requester dropping `s_tvalid` mid-packet does not release the grant; the arbiter waits indefinitely, with the watchdog counting beats only.
- The arbiter never drops, duplicates or reorders bytes within a requester.

## Timing
- Reset values:
  - state IDLE; `last` = N_REQ-1, so requester 0 has first priority.
  - `grant_id` = 0, `len_cnt` = 0.
  - `s_tready` = 0, `m_tvalid` = 0, `m_tdata` = 0, `busy` = 0, `wdog_trip` = 0.
- `rst` takes effect on the next edge in any state. A packet cut off mid-transfer is abandoned, and its requester re-arbitrates with a fresh header.
- Arbitration latency: request seen in IDLE → HDR valid on the next cycle. With `m_tready` held high, the header occupies 1 cycle and the first data beat is 2 cycles after the request.
- Packet gap: after the `tlast` beat there is 1 IDLE cycle with no output before the next grant.
- Simultaneous requests in IDLE: round-robin only; no requester is served twice while another is pending.
- `m_tvalid` stays high in HDR until accepted, and `m_tdata` is stable while `m_tvalid & ~m_tready` (AXI-Stream rule; requesters must also hold data stable).
- `busy` equals (state != IDLE), registered.
- `wdog_trip` is registered and high for exactly 1 cycle.

## Structure
- Package `axis_uart_pkg`:
  - FSM state enum `{IDLE, HDR, DATA}`
  - `HDR_ID_BITS` = 3
  - default `HDR_BASE`
  - `UART_BYTE_W` = 8
- Sub-module `rr_priority_select`: combinational, `N_REQ`-wide request vector plus `last` pointer → one-hot grant and index. It is instantiated once and reused by future bus arbiters.
- The FSM, counter and muxing live in the top of `axis_uart_tx_arbiter`.

## Test plan
- **Single requester:** requester 2 sends 3 bytes 0x11, 0x22, 0x33 (`tlast` on 0x33), `m_tready` = 1 → `m_tdata` sequence is A2, 11, 22, 33; `busy` falls 1 cycle after the 0x33 beat.
- **Fairness:** requesters 0, 1 and 3 each hold a valid 1-byte packet from reset → output is A0, x, A1, x, A3, x. With requester 0 re-requesting immediately, the next grant after 3 is 0.
- **Backpressure:** `m_tready` toggles 1-0-1 during HDR and DATA → header held stable while stalled, no byte lost, `s_tready` mirrors `m_tready` only on the granted bit.
- **Watchdog:** `MAX_LEN` = 4, requester 1 streams 6 bytes with no `tlast` → output is A1 + 4 bytes, `wdog_trip` pulses once, then A1 + 2 bytes.
- **`HDR_EN` = 0:** two packets from requesters 0 and 1 → raw bytes only, 1-cycle gap between packets.
- **Reset mid-packet:** `rst` asserted for 1 cycle during the DATA beat 2 of 5 → next cycle has `m_tvalid` = 0, `s_tready` = 0, `grant_id` = 0; a subsequent request restarts with a header.
